// File: rtl/cv32e40x_xif_aes_ctrl.sv
// XIF-to-saes32 sequencer: keeps offloaded AES32 instructions in an in-order
// tracking queue and runs each one on the FU once it is committed. The result
// is then held on the XIF result channel until the core takes it.
//
// state | meaning
// IDLE  | waiting for head entry to be committed (or killed, then dropped)
// EXEC  | head operands presented to FU, waiting for fu_ready_i
// RESP  | FU result held on result channel until result_ready_i
module cv32e40x_xif_aes_ctrl #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]    issue_id_i,
  input  logic [2*X_RFR_WIDTH-1:0] issue_rs_i,
  input  logic [1:0]               issue_rs_valid_i,
  output logic                     issue_accept_o,
  input  logic                     commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]    commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     fu_valid_o,
  output logic [X_RFR_WIDTH-1:0]   fu_rs1_o,
  output logic [X_RFR_WIDTH-1:0]   fu_rs2_o,
  output logic [1:0]               fu_bs_o,
  output logic [3:0]               fu_op_o,
  input  logic                     fu_ready_i,
  input  logic [X_RFR_WIDTH-1:0]   fu_rd_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic [X_RFR_WIDTH-1:0]   result_data_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,
  output logic                     busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] E_PEND = 2'd0;
  localparam logic [1:0] E_COMM = 2'd1;
  localparam logic [1:0] E_KILL = 2'd2;

  localparam logic [6:0] OPC_AES32 = 7'h33;
  localparam logic [4:0] F_DSI     = 5'b10101;
  localparam logic [4:0] F_DSMI    = 5'b10111;
  localparam logic [4:0] F_ESI     = 5'b10001;
  localparam logic [4:0] F_ESMI    = 5'b10011;

  // one-hot FU op {encsm,encs,decsm,decs} from funct5
  function automatic logic [3:0] op_decode(input logic [4:0] f5);
    case (f5)
      F_ESMI:  op_decode = 4'b1000;
      F_ESI:   op_decode = 4'b0100;
      F_DSMI:  op_decode = 4'b0010;
      F_DSI:   op_decode = 4'b0001;
      default: op_decode = 4'b0000;
    endcase
  endfunction

  logic [X_ID_WIDTH-1:0]  id_q    [DEPTH];
  logic [X_RFR_WIDTH-1:0] rs1_q   [DEPTH];
  logic [X_RFR_WIDTH-1:0] rs2_q   [DEPTH];
  logic [6:0]             funct_q [DEPTH];
  logic [4:0]             rd_q    [DEPTH];
  logic [1:0]             est_q   [DEPTH];
  logic [DEPTH-1:0]       vld_q;

  logic [PW-1:0]          head_q, tail_q;
  logic [PW:0]            count_q;
  logic [1:0]             state_q, state_d;
  logic [X_RFR_WIDTH-1:0] res_q, res_d;

  logic is_aes, push, pop, head_go, new_hit, head_pend_commit;
  logic unused_instr;

  assign unused_instr = ^issue_instr_i[24:12];

  assign is_aes = (issue_instr_i[6:0] == OPC_AES32) &&
                  ((issue_instr_i[29:25] == F_DSI)  || (issue_instr_i[29:25] == F_DSMI) ||
                   (issue_instr_i[29:25] == F_ESI)  || (issue_instr_i[29:25] == F_ESMI));

  assign issue_ready_o  = (count_q != FULL_CNT) && (&issue_rs_valid_i);
  assign issue_accept_o = issue_valid_i && issue_ready_o && is_aes;
  assign push           = issue_accept_o;
  assign new_hit        = commit_valid_i && (commit_id_i == issue_id_i);

  // a commit arriving this cycle for a pending head lets IDLE start at once
  assign head_pend_commit = (est_q[head_q] == E_PEND) && commit_valid_i &&
                            !commit_kill_i && (commit_id_i == id_q[head_q]);
  assign head_go = (state_q == ST_IDLE) && vld_q[head_q] &&
                   ((est_q[head_q] == E_COMM) || head_pend_commit);

  assign pop = ((state_q == ST_IDLE) && vld_q[head_q] && (est_q[head_q] == E_KILL)) ||
               ((state_q == ST_RESP) && result_ready_i);

  // entry valid/state tracking: commits, kills, push and pop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) est_q[i] <= E_PEND;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (est_q[i] == E_PEND) && commit_valid_i && (id_q[i] == commit_id_i))
          est_q[i] <= commit_kill_i ? E_KILL : E_COMM;
      end
      if (pop) vld_q[head_q] <= 1'b0;
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        est_q[tail_q] <= new_hit ? (commit_kill_i ? E_KILL : E_COMM) : E_PEND;
      end
    end
  end

  // entry payload, written only on push
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[tail_q]    <= issue_id_i;
      rs1_q[tail_q]   <= issue_rs_i[X_RFR_WIDTH-1:0];
      rs2_q[tail_q]   <= issue_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH];
      funct_q[tail_q] <= issue_instr_i[31:25];
      rd_q[tail_q]    <= issue_instr_i[11:7];
    end
  end

  // queue pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop)  head_q <= head_q + PW'(1);
      if (push) tail_q <= tail_q + PW'(1);
      if (push && !pop)      count_q <= count_q + (PW+1)'(1);
      else if (pop && !push) count_q <= count_q - (PW+1)'(1);
    end
  end

  // sequencer next state and result capture
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: if (head_go) state_d = ST_EXEC;
      ST_EXEC: if (fu_ready_i) begin
        state_d = ST_RESP;
        res_d   = fu_rd_i;
      end
      ST_RESP: if (result_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // sequencer state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  // FU and result channel drive, zeroed outside their active states
  always_comb begin
    fu_valid_o     = 1'b0;
    fu_rs1_o       = '0;
    fu_rs2_o       = '0;
    fu_bs_o        = 2'b00;
    fu_op_o        = 4'b0000;
    result_valid_o = 1'b0;
    result_id_o    = '0;
    result_data_o  = '0;
    result_rd_o    = 5'd0;
    result_we_o    = 1'b0;
    if (state_q == ST_EXEC) begin
      fu_valid_o = 1'b1;
      fu_rs1_o   = rs1_q[head_q];
      fu_rs2_o   = rs2_q[head_q];
      fu_bs_o    = funct_q[head_q][6:5];
      fu_op_o    = op_decode(funct_q[head_q][4:0]);
    end
    if (state_q == ST_RESP) begin
      result_valid_o = 1'b1;
      result_id_o    = id_q[head_q];
      result_data_o  = res_q;
      result_rd_o    = rd_q[head_q];
      result_we_o    = 1'b1;
    end
  end

  assign busy_o = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_cv32e40x_xif_aes_ctrl.sv
// Directed bench for the XIF AES sequencer with a simple combinational FU model.
module tb_cv32e40x_xif_aes_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [63:0] issue_rs;
  logic [1:0]  issue_rs_valid;
  logic        issue_accept;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        fu_valid;
  logic [31:0] fu_rs1, fu_rs2;
  logic [1:0]  fu_bs;
  logic [3:0]  fu_op;
  logic        fu_ready;
  logic [31:0] fu_rd;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;
  logic        busy;
  logic        fu_rdy_en;

  int total = 0;
  int bad   = 0;
  int fu_hs = 0;
  int res_hs = 0;
  logic [31:0] fu_log [$];

  always #5 clk = ~clk;

  cv32e40x_xif_aes_ctrl #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
    .issue_id_i(issue_id), .issue_rs_i(issue_rs), .issue_rs_valid_i(issue_rs_valid),
    .issue_accept_o(issue_accept),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .fu_valid_o(fu_valid), .fu_rs1_o(fu_rs1), .fu_rs2_o(fu_rs2), .fu_bs_o(fu_bs), .fu_op_o(fu_op),
    .fu_ready_i(fu_ready), .fu_rd_i(fu_rd),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
    .result_data_o(result_data), .result_rd_o(result_rd), .result_we_o(result_we),
    .busy_o(busy)
  );

  // toy FU: result depends on both operands, byte select and op
  assign fu_ready = fu_valid & fu_rdy_en;
  assign fu_rd    = fu_rs1 ^ {fu_rs2[15:0], fu_rs2[31:16]} ^ {26'h0, fu_bs, fu_op};

  always @(negedge clk) begin
    if (fu_valid && fu_ready) begin
      fu_hs++;
      fu_log.push_back(fu_rs1);
    end
    if (result_valid && result_ready) res_hs++;
  end

  localparam logic [4:0] F_DSI = 5'b10101, F_DSMI = 5'b10111, F_ESI = 5'b10001, F_ESMI = 5'b10011;

  function automatic logic [31:0] mk(input logic [1:0] bs, input logic [4:0] f5, input logic [4:0] rd);
    mk = {bs, f5, 5'd2, 5'd1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] expd(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] instr);
    logic [3:0] op;
    case (instr[29:25])
      F_ESMI:  op = 4'b1000;
      F_ESI:   op = 4'b0100;
      F_DSMI:  op = 4'b0010;
      F_DSI:   op = 4'b0001;
      default: op = 4'b0000;
    endcase
    expd = rs1 ^ {rs2[15:0], rs2[31:16]} ^ {26'h0, instr[31:30], op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] rs1,
                       input logic [31:0] rs2, output logic acc);
    issue_valid = 1'b1;
    issue_id    = id;
    issue_instr = instr;
    issue_rs    = {rs2, rs1};
    #1;
    acc = issue_accept;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    tick();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", issue_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({fu_valid, fu_op, result_valid, result_we, result_data} !== '0) begin
      bad++; $display("FAIL reset_outs got=%b/%h/%b/%b/%h want=0", fu_valid, fu_op, result_valid, result_we, result_data);
    end
    issue_rs_valid = 2'b01;
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL rs_valid_gate got=%b want=0", issue_ready); end
    issue_rs_valid = 2'b11;
    #1;
  endtask

  task automatic test_single();
    logic acc;
    logic [31:0] ins = mk(2'd0, F_ESI, 5'd5);
    issue(4'd3, ins, 32'h0, 32'h0, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_accept got=%b want=1", acc); end
    commit(4'd3, 1'b0);
    total++; if (fu_valid !== 1'b1 || fu_op !== 4'b0100) begin
      bad++; $display("FAIL single_exec got=%b/%b want=1/0100", fu_valid, fu_op);
    end
    tick();
    total++; if (result_valid !== 1'b1 || result_id !== 4'd3 || result_data !== 32'h4 ||
                 result_rd !== 5'd5 || result_we !== 1'b1) begin
      bad++; $display("FAIL single_result got=%b id=%0d data=%h rd=%0d want=1 id=3 data=00000004 rd=5",
                      result_valid, result_id, result_data, result_rd);
    end
    take_result();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
  endtask

  task automatic test_full();
    logic acc, ok;
    logic [31:0] ins [4];
    ins[0] = mk(2'd1, F_ESMI, 5'd10);
    ins[1] = mk(2'd2, F_DSI, 5'd11);
    ins[2] = mk(2'd3, F_DSMI, 5'd12);
    ins[3] = mk(2'd0, F_ESI, 5'd13);
    for (int i = 0; i < 4; i++) issue(4'(i), ins[i], 32'h1000 * (i + 1), 32'h00AB_0000 + i, acc);
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", issue_ready); end
    issue(4'd4, ins[0], 32'h0, 32'h0, acc);
    total++; if (acc !== 1'b0) begin bad++; $display("FAIL full_accept got=%b want=0", acc); end
    commit(4'd0, 1'b0);
    wait_valid(ok);
    total++; if (!ok || result_id !== 4'd0) begin bad++; $display("FAIL full_first got=%b/%0d want=1/0", ok, result_id); end
    take_result();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b want=1", issue_ready); end
    commit(4'd1, 1'b0);
    commit(4'd2, 1'b0);
    commit(4'd3, 1'b0);
    for (int i = 1; i < 4; i++) begin
      wait_valid(ok);
      total++;
      if (!ok || result_id !== 4'(i) || result_rd !== 5'(10 + i) ||
          result_data !== expd(32'h1000 * (i + 1), 32'h00AB_0000 + i, ins[i])) begin
        bad++; $display("FAIL full_drain_%0d got=%b id=%0d rd=%0d data=%h want id=%0d data=%h", i, ok, result_id,
                        result_rd, result_data, i, expd(32'h1000 * (i + 1), 32'h00AB_0000 + i, ins[i]));
      end
      take_result();
    end
  endtask

  task automatic test_kill();
    logic acc, ok;
    int f0 = fu_hs, r0 = res_hs;
    logic [31:0] ins = mk(2'd2, F_DSMI, 5'd7);
    issue(4'd5, ins, 32'h5555_0000, 32'h1, acc);
    issue(4'd6, ins, 32'h6666_0000, 32'h2, acc);
    commit(4'd5, 1'b1);
    commit(4'd6, 1'b0);
    wait_valid(ok);
    total++; if (!ok || result_id !== 4'd6 || result_data !== expd(32'h6666_0000, 32'h2, ins)) begin
      bad++; $display("FAIL kill_result got=%b id=%0d data=%h want id=6 data=%h", ok, result_id, result_data,
                      expd(32'h6666_0000, 32'h2, ins));
    end
    take_result();
    repeat (3) tick();
    total++; if (fu_hs - f0 !== 1 || res_hs - r0 !== 1 || fu_log[$] !== 32'h6666_0000) begin
      bad++; $display("FAIL kill_counts got fu=%0d res=%0d rs1=%h want fu=1 res=1 rs1=66660000", fu_hs - f0, res_hs - r0, fu_log[$]);
    end
  endtask

  task automatic test_order();
    logic acc, ok;
    int f0 = fu_hs;
    logic [31:0] ins = mk(2'd1, F_DSI, 5'd9);
    issue(4'd6, ins, 32'h0000_0600, 32'h0, acc);
    issue(4'd7, ins, 32'h0000_0700, 32'h0, acc);
    commit(4'd7, 1'b0);
    repeat (4) tick();
    total++; if (result_valid !== 1'b0 || fu_hs !== f0) begin
      bad++; $display("FAIL order_wait got valid=%b fu=%0d want valid=0 fu=%0d", result_valid, fu_hs, f0);
    end
    commit(4'd6, 1'b0);
    wait_valid(ok);
    total++; if (!ok || result_id !== 4'd6) begin bad++; $display("FAIL order_first got=%b/%0d want=1/6", ok, result_id); end
    take_result();
    wait_valid(ok);
    total++; if (!ok || result_id !== 4'd7) begin bad++; $display("FAIL order_second got=%b/%0d want=1/7", ok, result_id); end
    take_result();
  endtask

  task automatic test_stall_hold();
    logic acc, ok;
    int f0;
    logic [31:0] ins = mk(2'd3, F_ESMI, 5'd20);
    logic [31:0] want = expd(32'hA5A5_1234, 32'hDEAD_BEEF, ins);
    fu_rdy_en = 1'b0;
    issue(4'd9, ins, 32'hA5A5_1234, 32'hDEAD_BEEF, acc);
    commit(4'd9, 1'b0);
    repeat (3) tick();
    total++; if (fu_valid !== 1'b1 || fu_rs1 !== 32'hA5A5_1234 || fu_rs2 !== 32'hDEAD_BEEF || fu_bs !== 2'd3) begin
      bad++; $display("FAIL stall_fu got=%b %h %h %0d want=1 a5a51234 deadbeef 3", fu_valid, fu_rs1, fu_rs2, fu_bs);
    end
    fu_rdy_en = 1'b1;
    wait_valid(ok);
    f0 = fu_hs;
    issue(4'd10, mk(2'd0, F_DSI, 5'd21), 32'h10, 32'h0, acc);
    commit(4'd10, 1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (!ok || result_valid !== 1'b1 || result_data !== want || result_id !== 4'd9) begin
        bad++; $display("FAIL hold_%0d got=%b id=%0d data=%h want=1 id=9 data=%h", i, result_valid, result_id, result_data, want);
      end
      tick();
    end
    total++; if (fu_hs !== f0) begin bad++; $display("FAIL hold_no_fu got=%0d want=%0d", fu_hs, f0); end
    take_result();
    wait_valid(ok);
    total++; if (!ok || result_id !== 4'd10 || result_data !== 32'h11) begin
      bad++; $display("FAIL hold_next got=%b id=%0d data=%h want id=10 data=00000011", ok, result_id, result_data);
    end
    take_result();
  endtask

  task automatic test_non_aes();
    logic acc, ok;
    issue(4'd11, 32'h0000_0033, 32'h1, 32'h2, acc);
    total++; if (acc !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL nonaes got acc=%b busy=%b want 0/0", acc, busy);
    end
    commit_valid = 1'b1;
    commit_id    = 4'd12;
    commit_kill  = 1'b0;
    issue(4'd12, mk(2'd0, F_ESI, 5'd1), 32'h0000_1200, 32'h0, acc);
    commit_valid = 1'b0;
    wait_valid(ok);
    total++; if (!ok || result_id !== 4'd12) begin bad++; $display("FAIL same_cycle_commit got=%b/%0d want=1/12", ok, result_id); end
    take_result();
  endtask

  task automatic test_reset_resp();
    logic acc, ok;
    int r0;
    issue(4'd1, mk(2'd1, F_ESI, 5'd3), 32'h77, 32'h0, acc);
    issue(4'd2, mk(2'd1, F_ESI, 5'd3), 32'h88, 32'h0, acc);
    commit(4'd1, 1'b0);
    commit(4'd2, 1'b0);
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_resp_reach got=0 want=1"); end
    r0 = res_hs;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || result_valid !== 1'b0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL rst_resp got busy=%b valid=%b ready=%b want 0/0/1", busy, result_valid, issue_ready);
    end
    result_ready = 1'b1;
    repeat (5) tick();
    result_ready = 1'b0;
    total++; if (res_hs !== r0 || fu_valid !== 1'b0) begin
      bad++; $display("FAIL rst_flush got res=%0d fu=%b want res=%0d fu=0", res_hs, fu_valid, r0);
    end
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_instr = '0; issue_id = '0; issue_rs = '0;
    issue_rs_valid = 2'b11; commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
    result_ready = 1'b0; fu_rdy_en = 1'b1;
    test_reset();
    test_single();
    test_full();
    test_kill();
    test_order();
    test_stall_hold();
    test_non_aes();
    test_reset_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
